// File: rtl/btn_code_sequencer.sv
// -----------------------------------------------------------------------------
// btn_code_sequencer
//
// Purpose:
//   Produces the 2-bit select code for the board's 2-to-4 decoder stage.
//   Two raw push buttons (step, mode) are synchronised, debounced and
//   edge-detected. In MANUAL mode the code advances once per step press.
//   In AUTO mode it advances every AUTO_CYC clocks. The code wraps 3 -> 0.
//
// Build option:
//   GRAY_CODE_EN  defined   : code sequence 00,01,11,10,00 (Gray mapping)
//                 undefined : code sequence 00,01,10,11,00 (binary)
//
// Parameters:
//   DEBOUNCE_CYC  consecutive differing cycles before a button level is accepted (>= 2)
//   AUTO_CYC      clocks between advances in AUTO mode (>= 2)
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset (sync release expected upstream)
//   btn_step    in   raw step button, active-high, asynchronous, bouncy
//   btn_mode    in   raw mode button, active-high, asynchronous, bouncy
//   code        out  [1:0] registered select code
//   auto_mode   out  1 = AUTO, 0 = MANUAL; this is the FSM state itself
//   step_pulse  out  one-cycle strobe, high in the cycle code takes a new value
//
// Strobe semantics: step_pulse is a plain registered strobe with no handshake;
// the consumer must sample it every cycle. There is no back-pressure.
// -----------------------------------------------------------------------------
module btn_code_sequencer #(
   parameter int DEBOUNCE_CYC = 500_000,
   parameter int AUTO_CYC     = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_step,
   input  logic       btn_mode,
   output logic [1:0] code,
   output logic       auto_mode,
   output logic       step_pulse
);

   localparam int DBW = $clog2(DEBOUNCE_CYC);
   localparam int TKW = $clog2(AUTO_CYC);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
   localparam logic [TKW-1:0] TK_LAST = TKW'(AUTO_CYC - 1);

   typedef enum logic {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } state_t;

   // Bit 0 = step button, bit 1 = mode button throughout.
   logic [1:0]     raw;
   logic [1:0]     sync1;
   logic [1:0]     sync2;
   logic [1:0]     stable;
   logic [1:0]     stable_prev;
   logic [1:0]     press;
   logic [DBW-1:0] db_cnt [2];

   state_t         state;
   state_t         state_nxt;
   logic [TKW-1:0] tick;
   logic [TKW-1:0] tick_nxt;
   logic           adv;
   logic [1:0]     idx;
   logic [1:0]     idx_nxt;

   function automatic logic [1:0] map_code(input logic [1:0] i);
`ifdef GRAY_CODE_EN
      return i ^ {1'b0, i[1]};
`else
      return i;
`endif
   endfunction

   assign raw     = {btn_mode, btn_step};
   // Rising edge of the debounced level; releases produce nothing.
   assign press   = stable & ~stable_prev;
   assign idx_nxt = idx + 2'd1;

   // Synchronisers and debouncers. The counter only runs while the synced
   // level disagrees with the accepted level, so any bounce back to the
   // accepted level restarts the count from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1       <= '0;
         sync2       <= '0;
         stable      <= '0;
         stable_prev <= '0;
         db_cnt[0]   <= '0;
         db_cnt[1]   <= '0;
      end else begin
         sync1       <= raw;
         sync2       <= sync1;
         stable_prev <= stable;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= MANUAL;
         tick  <= '0;
      end else begin
         state <= state_nxt;
         tick  <= tick_nxt;
      end
   end

   // Next state and advance request. A mode press always wins: any step
   // press or auto tick in the same cycle is dropped.
   always_comb begin
      state_nxt = state;
      tick_nxt  = tick;
      adv       = 1'b0;
      case (state)
         MANUAL: begin
            // Held at zero so AUTO always starts counting from 0.
            tick_nxt = '0;
            if (press[1]) begin
               state_nxt = AUTO;
            end else if (press[0]) begin
               adv = 1'b1;
            end
         end
         AUTO: begin
            if (press[1]) begin
               state_nxt = MANUAL;
               tick_nxt  = '0;
            end else if (tick == TK_LAST) begin
               adv      = 1'b1;
               tick_nxt = '0;
            end else begin
               tick_nxt = tick + 1'b1;
            end
         end
         default: begin
            state_nxt = MANUAL;
            tick_nxt  = '0;
         end
      endcase
   end

   // Index, output code and strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx        <= 2'd0;
         code       <= 2'd0;
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= adv;
         if (adv) begin
            idx  <= idx_nxt;
            code <= map_code(idx_nxt);
         end
      end
   end

   assign auto_mode = (state == AUTO);

endmodule

// File: tb/tb_btn_code_sequencer.sv
// -----------------------------------------------------------------------------
// tb_btn_code_sequencer
//
// Directed bench for btn_code_sequencer with DEBOUNCE_CYC=4, AUTO_CYC=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Segment vectors hold the buttons for a number of cycles, then compare the
// final code, auto_mode and the number of step_pulse cycles seen.
// Build option GRAY_CODE_EN selects the Gray expected mapping.
// -----------------------------------------------------------------------------
module tb_btn_code_sequencer;

   localparam int DEB = 4;
   localparam int AUT = 8;

   logic       clk;
   logic       rst;
   logic       btn_step;
   logic       btn_mode;
   logic [1:0] code;
   logic       auto_mode;
   logic       step_pulse;

   btn_code_sequencer #(
      .DEBOUNCE_CYC(DEB),
      .AUTO_CYC    (AUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_step  (btn_step),
      .btn_mode  (btn_mode),
      .code      (code),
      .auto_mode (auto_mode),
      .step_pulse(step_pulse)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       step;
      logic       mode;
      int         ncyc;
      logic [1:0] exp_idx;
      logic       exp_auto;
      int         exp_pulses;
   } vec_t;

   vec_t vt [0:39];
   int   n_vt = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic logic [1:0] map_code(input logic [1:0] i);
`ifdef GRAY_CODE_EN
      case (i)
         2'd0:    return 2'b00;
         2'd1:    return 2'b01;
         2'd2:    return 2'b11;
         default: return 2'b10;
      endcase
`else
      return i;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_vec(input logic s, input logic m, input int n,
                          input logic [1:0] ei, input logic ea, input int ep);
      vt[n_vt].step       = s;
      vt[n_vt].mode       = m;
      vt[n_vt].ncyc       = n;
      vt[n_vt].exp_idx    = ei;
      vt[n_vt].exp_auto   = ea;
      vt[n_vt].exp_pulses = ep;
      n_vt++;
   endtask

   // Driver: apply vectors lo..hi-1, each starting and ending on a falling edge.
   task automatic run_vecs(input int lo, input int hi);
      int pulses;
      for (int i = lo; i < hi; i++) begin
         btn_step = vt[i].step;
         btn_mode = vt[i].mode;
         pulses   = 0;
         for (int c = 0; c < vt[i].ncyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (step_pulse === 1'b1) pulses++;
         end
         chk($sformatf("vec%0d_code", i), code, map_code(vt[i].exp_idx));
         chk($sformatf("vec%0d_auto", i), auto_mode, vt[i].exp_auto);
         chk($sformatf("vec%0d_pulses", i), pulses, vt[i].exp_pulses);
      end
   endtask

   initial begin
      logic [1:0] e_idx;
      logic       e_auto;
      logic       e_pulse;
      int         a_lo;
      int         a_hi;
      int         b_hi;

      // Table A: remaining manual presses with wrap, then a bouncy button.
      add_vec(1'b0, 1'b0, 8, 2'd1, 1'b0, 0);
      add_vec(1'b1, 1'b0, 12, 2'd2, 1'b0, 1);
      add_vec(1'b0, 1'b0, 8, 2'd2, 1'b0, 0);
      add_vec(1'b1, 1'b0, 12, 2'd3, 1'b0, 1);
      add_vec(1'b0, 1'b0, 8, 2'd3, 1'b0, 0);
      add_vec(1'b1, 1'b0, 12, 2'd0, 1'b0, 1);
      add_vec(1'b0, 1'b0, 8, 2'd0, 1'b0, 0);
      for (int b = 0; b < 5; b++) begin
         add_vec(1'b1, 1'b0, 2, 2'd0, 1'b0, 0);
         add_vec(1'b0, 1'b0, 2, 2'd0, 1'b0, 0);
      end
      add_vec(1'b0, 1'b0, 8, 2'd0, 1'b0, 0);
      a_lo = 0;
      a_hi = n_vt;
      // Table B: continues AUTO after the 40-cycle hand sequence.
      // Auto advances land on cycles 47, 55, 63 counted from the mode press.
      add_vec(1'b1, 1'b0, 12, 2'd1, 1'b1, 1);  // step ignored in AUTO
      add_vec(1'b0, 1'b0, 8, 2'd2, 1'b1, 1);
      add_vec(1'b0, 1'b1, 12, 2'd3, 1'b0, 1);  // exit AUTO at cycle 67
      add_vec(1'b0, 1'b0, 8, 2'd3, 1'b0, 0);
      add_vec(1'b0, 1'b0, 16, 2'd3, 1'b0, 0);  // code frozen in MANUAL
      add_vec(1'b1, 1'b1, 12, 2'd3, 1'b1, 0);  // collision: mode wins
      add_vec(1'b0, 1'b0, 2, 2'd3, 1'b1, 0);
      b_hi = n_vt;
      // Table C: step held through reset release counts as one press.
      add_vec(1'b1, 1'b0, 12, 2'd1, 1'b0, 1);
      add_vec(1'b0, 1'b0, 8, 2'd1, 1'b0, 0);

      // Reset asserted mid-cycle with buttons low: outputs clear asynchronously.
      rst      = 1'b0;
      btn_step = 1'b0;
      btn_mode = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_code", code, 2'b00);
      chk("rst_auto", auto_mode, 1'b0);
      chk("rst_pulse", step_pulse, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single press, exact latency: code changes at edge DEB+3 = 7.
      btn_step = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("step_code_e%0d", k), code, map_code((k >= 7) ? 2'd1 : 2'd0));
         chk($sformatf("step_pulse_e%0d", k), step_pulse, (k == 7) ? 1'b1 : 1'b0);
      end
      btn_step = 1'b0;

      run_vecs(a_lo, a_hi);

      // AUTO entry at edge 7, advances at 15, 23, 31, 39.
      btn_mode = 1'b1;
      e_idx    = 2'd0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         e_auto  = (k >= 7);
         e_pulse = (k >= 15) && (((k - 7) % 8) == 0);
         if (e_pulse) e_idx = e_idx + 2'd1;
         chk($sformatf("auto_mode_c%0d", k), auto_mode, e_auto);
         chk($sformatf("auto_pulse_c%0d", k), step_pulse, e_pulse);
         chk($sformatf("auto_code_c%0d", k), code, map_code(e_idx));
         if (k == 12) btn_mode = 1'b0;
      end

      run_vecs(a_hi, b_hi);

      // Reset mid-AUTO, step held through the reset.
      btn_step = 1'b1;
      btn_mode = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_code", code, 2'b00);
      chk("midrst_auto", auto_mode, 1'b0);
      chk("midrst_pulse", step_pulse, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_vecs(b_hi, n_vt);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
